mips_fetch_stage: RTL and testbench
===================================

Name: mips_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline; directly drives the instruction memory's address, write-data and write-enable ports, and consumes its read data.
- After reset it runs a boot phase that loads program words sequentially into instruction memory.
- It then fetches one instruction per cycle from the PC into the IF/ID pipeline register.
- Supports stall, branch/jump redirect, and a sticky fault/halt on bad fetch addresses.

Parameters:
- DataWidth, 32, instruction/data word width in bits.
- Depth, 100, instruction memory depth in words; must match the instruction memory instance.
- ResetPC, 0, byte address of the first fetch after boot; must be word-aligned.

Ports:
- clk  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- boot_valid  input  1  boot word present on boot_data this cycle.
- boot_data  input  DataWidth  program word to load.
- boot_done  input  1  pulse: end of program load.
- stall  input  1  hold PC and IF/ID this cycle (hazard unit).
- redirect  input  1  taken branch/jump this cycle.
- redirect_pc  input  DataWidth  byte address of the redirect target.
- imem_rd_data  input  DataWidth  combinational read data from instruction memory.
- imem_addr  output  DataWidth  word index into instruction memory.
- imem_wr_data  output  DataWidth  write data to instruction memory.
- imem_wr_en  output  1  write enable to instruction memory.
- if_id_instr  output  DataWidth  registered instruction.
- if_id_pc_plus4  output  DataWidth  registered PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- pc  output  DataWidth  current fetch PC, byte address.
- boot_count  output  DataWidth  number of words loaded.
- running  output  1  FSM is in RUN.
- fault  output  1  sticky; fetch or redirect address error.

Behaviour:

Reset (RST low, asynchronous):
- FSM=BOOT, pc=ResetPC, boot_count=0.
- if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, fault=0.
- Reset asserted mid-boot or mid-run aborts immediately; boot restarts at word 0.

FSM states: BOOT, RUN, HALT.

Combinational memory drive:
- BOOT: imem_addr=boot_count, imem_wr_data=boot_data, imem_wr_en=boot_valid.
- RUN/HALT: imem_addr=pc>>2 (zero-extended), imem_wr_data=0, imem_wr_en=0.

BOOT:
- Each clock with boot_valid=1: the word is written at index boot_count, then boot_count increments.
- boot_done=1 moves to RUN at the next edge. If boot_valid is also 1 that cycle, the word is written first.
- When the write at index Depth-1 completes, move to RUN automatically; later boot_valid is ignored.
- stall and redirect are ignored in BOOT; if_id_valid stays 0.

RUN, per rising edge, priority highest first:
1. redirect=1:
   - If redirect_pc[1:0]!=0 or (redirect_pc>>2)>=Depth: fault<=1, go to HALT, if_id_valid<=0.
   - Otherwise: pc<=redirect_pc, if_id_instr<=0 (NOP), if_id_valid<=0. This squashes the wrong-path instruction, so the redirect penalty is 1 bubble.
   - Redirect beats stall.
2. stall=1: pc, if_id_instr, if_id_pc_plus4 and if_id_valid all hold.
3. (pc>>2)>=Depth: fault<=1, go to HALT, if_id_valid<=0, if_id_instr<=0.
4. Otherwise:
   - if_id_instr<=imem_rd_data, if_id_pc_plus4<=pc+4, if_id_valid<=1.
   - pc<=pc+4, arithmetic modulo 2^DataWidth.

Latency and cadence:
- Instruction at pc appears on if_id_instr one edge after pc is presented.
- Steady-state throughput is 1 instruction per cycle.

HALT:
- pc holds; IF/ID is forced to instr=0 and valid=0.
- fault stays 1; inputs are ignored; exit only by reset.

Outputs:
- running=1 only in RUN.
- fault only sets in RUN and only clears on reset.

Test Plan:
- Boot sequencing: reset; boot_valid for 3 cycles with 0x20080005, 0x20090003, 0x01095020; then pulse boot_done. Expect imem_wr_en pulses at imem_addr 0,1,2; boot_count=3; running=1 next edge; pc=0.
- Fetch cadence: after that boot, run 3 cycles with no stall. Expect if_id_instr 0x20080005/0x20090003/0x01095020 on successive edges, if_id_pc_plus4 4/8/12, if_id_valid=1, pc=12.
- Stall: stall=1 for 2 cycles at pc=4. Expect pc stays 4 and IF/ID unchanged. On release, the next edge loads the word-1 instruction.
- Redirect vs stall: redirect=1 and stall=1 with redirect_pc=0x8. Expect pc=8, if_id_valid=0, if_id_instr=0; the following edge fetches 0x01095020.
- Fault paths:
  - redirect_pc=0x6 gives fault=1, running=0, pc held.
  - Separately, redirect_pc=400 with Depth=100 gives fault=1, HALT.
  - Falling off the end (pc reaches 400) gives fault=1 on that edge, if_id_valid=0.
- Auto-finish and reset: load 100 words with no boot_done. Expect running=1 after the 100th write and a 101st boot_valid not written. Assert RST mid-run: all outputs return to reset values asynchronously and the FSM is back in BOOT.

Source files
------------

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: boots program words into imem, then fetches one instruction per cycle into IF/ID.
// Latency: instruction at pc appears on if_id_instr one edge after pc is presented; redirect costs one bubble.
// Backpressure: stall holds pc and IF/ID; redirect overrides stall; a bad fetch/redirect address halts until reset.
module mips_fetch_stage #(
  parameter int DataWidth = 32,
  parameter int Depth     = 100,
  parameter int ResetPC   = 0
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 boot_valid,
  input  logic [DataWidth-1:0] boot_data,
  input  logic                 boot_done,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [DataWidth-1:0] redirect_pc,
  input  logic [DataWidth-1:0] imem_rd_data,
  output logic [DataWidth-1:0] imem_addr,
  output logic [DataWidth-1:0] imem_wr_data,
  output logic                 imem_wr_en,
  output logic [DataWidth-1:0] if_id_instr,
  output logic [DataWidth-1:0] if_id_pc_plus4,
  output logic                 if_id_valid,
  output logic [DataWidth-1:0] pc,
  output logic [DataWidth-1:0] boot_count,
  output logic                 running,
  output logic                 fault
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [DataWidth-1:0] ONE      = DataWidth'(1);
  localparam logic [DataWidth-1:0] FOUR     = DataWidth'(4);
  localparam logic [DataWidth-1:0] DEPTH_W  = DataWidth'(Depth);
  localparam logic [DataWidth-1:0] LAST_IDX = DataWidth'(Depth - 1);
  localparam logic [DataWidth-1:0] RESET_PC = DataWidth'(ResetPC);

  state_t                 state_q;
  logic [DataWidth-1:0]   pc_q;
  logic [DataWidth-1:0]   boot_count_q;
  logic [DataWidth-1:0]   instr_q;
  logic [DataWidth-1:0]   pc_plus4_q;
  logic                   valid_q;
  logic                   fault_q;

  logic [DataWidth-1:0]   pc_plus4_d;
  logic                   pc_oob;
  logic                   redirect_bad;

  // Sequential pc wraps modulo 2^DataWidth; word index out of range means the fetch has run off imem.
  assign pc_plus4_d   = pc_q + FOUR;
  assign pc_oob       = (pc_q >> 2) >= DEPTH_W;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || ((redirect_pc >> 2) >= DEPTH_W);

  // imem port is owned by the boot loader in BOOT and by the fetch pc otherwise.
  always_comb begin
    imem_addr    = pc_q >> 2;
    imem_wr_data = '0;
    imem_wr_en   = 1'b0;
    if (state_q == S_BOOT) begin
      imem_addr    = boot_count_q;
      imem_wr_data = boot_data;
      imem_wr_en   = boot_valid;
    end
  end

  // Boot/run/halt FSM with pc and IF/ID register updates.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      boot_count_q <= '0;
      instr_q      <= '0;
      pc_plus4_q   <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          // A final word written alongside boot_done still lands before RUN.
          if (boot_valid) begin
            boot_count_q <= boot_count_q + ONE;
            if (boot_count_q == LAST_IDX) state_q <= S_RUN;
          end
          if (boot_done) state_q <= S_RUN;
        end
        S_RUN: begin
          if (redirect) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            if (redirect_bad) begin
              fault_q <= 1'b1;
              state_q <= S_HALT;
            end else begin
              pc_q <= redirect_pc;
            end
          end else if (stall) begin
            // Hold everything for the hazard unit.
          end else if (pc_oob) begin
            fault_q <= 1'b1;
            state_q <= S_HALT;
            instr_q <= '0;
            valid_q <= 1'b0;
          end else begin
            instr_q    <= imem_rd_data;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= 1'b1;
            pc_q       <= pc_plus4_d;
          end
        end
        S_HALT: begin
          instr_q <= '0;
          valid_q <= 1'b0;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc_plus4_q;
  assign if_id_valid    = valid_q;
  assign pc             = pc_q;
  assign boot_count     = boot_count_q;
  assign running        = (state_q == S_RUN);
  assign fault          = fault_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: table of per-cycle vectors plus directed multi-cycle sequences.
// A small instruction memory model sits on the imem port.
module tb_mips_fetch_stage;

  localparam int DW = 32;
  localparam int DEPTH = 100;
  localparam logic [31:0] W0 = 32'h2008_0005;
  localparam logic [31:0] W1 = 32'h2009_0003;
  localparam logic [31:0] W2 = 32'h0109_5020;

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic          boot_valid = 1'b0;
  logic [DW-1:0] boot_data = '0;
  logic          boot_done = 1'b0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [DW-1:0] redirect_pc = '0;
  logic [DW-1:0] imem_rd_data;
  logic [DW-1:0] imem_addr;
  logic [DW-1:0] imem_wr_data;
  logic          imem_wr_en;
  logic [DW-1:0] if_id_instr;
  logic [DW-1:0] if_id_pc_plus4;
  logic          if_id_valid;
  logic [DW-1:0] pc;
  logic [DW-1:0] boot_count;
  logic          running;
  logic          fault;

  int checks = 0;
  int errors = 0;

  mips_fetch_stage #(.DataWidth(DW), .Depth(DEPTH), .ResetPC(0)) dut (
    .clk(clk), .RST(RST),
    .boot_valid(boot_valid), .boot_data(boot_data), .boot_done(boot_done),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_rd_data(imem_rd_data), .imem_addr(imem_addr),
    .imem_wr_data(imem_wr_data), .imem_wr_en(imem_wr_en),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .pc(pc), .boot_count(boot_count), .running(running), .fault(fault)
  );

  always #5 clk = ~clk;

  // Instruction memory model: synchronous write, combinational read.
  logic [DW-1:0] mem [0:DEPTH-1];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      if (imem_wr_en && imem_addr < DEPTH) mem[imem_addr] <= imem_wr_data;
    end
  end
  assign imem_rd_data = (imem_addr < DEPTH) ? mem[imem_addr] : '0;

  typedef struct {
    logic        bv;
    logic [31:0] bd;
    logic        bdn;
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        e_wr_en;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_p4;
    logic        e_valid;
    logic        e_run;
    logic        e_fault;
    logic [31:0] e_bc;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic bv, input logic [31:0] bd, input logic bdn,
                              input logic st, input logic rd, input logic [31:0] rpc,
                              input logic e_wr_en, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_p4, input logic e_valid,
                              input logic e_run, input logic e_fault, input logic [31:0] e_bc);
    vec_t v;
    v.bv = bv; v.bd = bd; v.bdn = bdn; v.st = st; v.rd = rd; v.rpc = rpc;
    v.e_wr_en = e_wr_en; v.e_addr = e_addr; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_p4 = e_p4; v.e_valid = e_valid; v.e_run = e_run; v.e_fault = e_fault; v.e_bc = e_bc;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int idx, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic [31:0] e_p4, input logic e_valid,
                           input logic e_run, input logic e_fault, input logic [31:0] e_bc);
    chk({tag, ".pc"}, idx, pc, e_pc);
    chk({tag, ".instr"}, idx, if_id_instr, e_instr);
    chk({tag, ".pc_plus4"}, idx, if_id_pc_plus4, e_p4);
    chk({tag, ".valid"}, idx, 32'(if_id_valid), 32'(e_valid));
    chk({tag, ".running"}, idx, 32'(running), 32'(e_run));
    chk({tag, ".fault"}, idx, 32'(fault), 32'(e_fault));
    chk({tag, ".boot_count"}, idx, boot_count, e_bc);
  endtask

  // Drive inputs on the falling edge and let combinational outputs settle.
  task automatic drive(input logic bv, input logic [31:0] bd, input logic bdn,
                       input logic st, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    boot_valid = bv; boot_data = bd; boot_done = bdn;
    stall = st; redirect = rd; redirect_pc = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b0;
    boot_valid = 1'b0; boot_done = 1'b0; stall = 1'b0; redirect = 1'b0;
    repeat (2) @(negedge clk);
    RST = 1'b1;
  endtask

  initial begin
    // Boot three words, then exercise fetch, stall, redirect and a misaligned redirect fault.
    vecs[0]  = mk(1, W0, 0, 0, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 1);
    vecs[1]  = mk(1, W1, 0, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0, 0, 2);
    vecs[2]  = mk(1, W2, 0, 0, 0, 0,  1, 2,  0, 0, 0, 0, 0, 0, 3);
    vecs[3]  = mk(0, 0,  1, 0, 0, 0,  0, 3,  0, 0, 0, 0, 1, 0, 3);
    vecs[4]  = mk(0, 0,  0, 0, 0, 0,  0, 0,  4, W0, 4, 1, 1, 0, 3);
    vecs[5]  = mk(0, 0,  0, 1, 0, 0,  0, 1,  4, W0, 4, 1, 1, 0, 3);
    vecs[6]  = mk(0, 0,  0, 1, 0, 0,  0, 1,  4, W0, 4, 1, 1, 0, 3);
    vecs[7]  = mk(0, 0,  0, 0, 0, 0,  0, 1,  8, W1, 8, 1, 1, 0, 3);
    vecs[8]  = mk(0, 0,  0, 0, 0, 0,  0, 2,  12, W2, 12, 1, 1, 0, 3);
    vecs[9]  = mk(0, 0,  0, 0, 0, 0,  0, 3,  16, 0, 16, 1, 1, 0, 3);
    vecs[10] = mk(0, 0,  0, 1, 1, 8,  0, 4,  8, 0, 16, 0, 1, 0, 3);
    vecs[11] = mk(0, 0,  0, 0, 0, 0,  0, 2,  12, W2, 12, 1, 1, 0, 3);
    vecs[12] = mk(0, 0,  0, 0, 1, 6,  0, 3,  12, 0, 12, 0, 0, 1, 3);
    vecs[13] = mk(1, 32'hDEAD_BEEF, 1, 1, 1, 0,  0, 3,  12, 0, 12, 0, 0, 1, 3);

    do_reset();
    #1;
    chk_state("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].bv, vecs[i].bd, vecs[i].bdn, vecs[i].st, vecs[i].rd, vecs[i].rpc);
      chk("vec.wr_en", i, 32'(imem_wr_en), 32'(vecs[i].e_wr_en));
      chk("vec.addr", i, imem_addr, vecs[i].e_addr);
      if (vecs[i].e_wr_en) chk("vec.wr_data", i, imem_wr_data, vecs[i].bd);
      tick();
      chk_state("vec", i, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_p4, vecs[i].e_valid,
                vecs[i].e_run, vecs[i].e_fault, vecs[i].e_bc);
    end
    chk("mem.w0", 0, mem[0], W0);
    chk("mem.w2", 2, mem[2], W2);

    // Full-depth boot without boot_done: RUN after the last word, extra words ignored.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h100 + 32'(i), 0, 0, 0, 0);
      chk("auto.addr", i, imem_addr, 32'(i));
      tick();
      if (i >= DEPTH - 2) begin
        chk("auto.running", i, 32'(running), (i == DEPTH - 1) ? 32'd1 : 32'd0);
        chk("auto.boot_count", i, boot_count, 32'(i + 1));
      end
    end
    drive(1, 32'h0000_0BAD, 0, 0, 0, 0);
    chk("auto.extra_wr_en", 0, 32'(imem_wr_en), 0);
    tick();
    chk_state("auto.fetch", 0, 4, 32'h100, 4, 1, 1, 0, 100);
    chk("auto.mem99", 99, mem[99], 32'h163);

    // Run off the end of memory: last word fetches, next edge faults.
    drive(0, 0, 0, 0, 1, 396);
    tick();
    chk_state("end.redir", 0, 396, 0, 4, 0, 1, 0, 100);
    drive(0, 0, 0, 0, 0, 0);
    chk("end.addr", 0, imem_addr, 99);
    tick();
    chk_state("end.last", 0, 400, 32'h163, 400, 1, 1, 0, 100);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_state("end.fault", 0, 400, 0, 400, 0, 0, 1, 100);
    drive(0, 0, 0, 0, 1, 8);
    tick();
    chk_state("end.halt", 0, 400, 0, 400, 0, 0, 1, 100);

    // Asynchronous reset in the middle of RUN.
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_state("midrun", 0, 8, 32'h101, 8, 1, 1, 0, 0);
    #2;
    RST = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("async_rst.addr", 0, imem_addr, 0);
    @(negedge clk);
    RST = 1'b1;

    // Reset during boot restarts at word 0; then an out-of-range redirect faults.
    drive(1, W0, 0, 0, 0, 0);
    tick();
    drive(1, W1, 0, 0, 0, 0);
    tick();
    chk("midboot.boot_count", 0, boot_count, 2);
    do_reset();
    #1;
    chk("midboot.rst_count", 0, boot_count, 0);
    drive(1, W0, 1, 0, 0, 0);
    chk("midboot.addr", 0, imem_addr, 0);
    tick();
    chk_state("boot_done_wr", 0, 0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 1, 400);
    tick();
    chk_state("redir400", 0, 0, 0, 0, 0, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
